// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control core.
//   state_t    : controller states (RUN / PAUSED / ADJUST)
//   MAX_COUNT  : terminal value of the minutes and seconds fields
//   SEL_MIN/SEL_SEC : values of the synchronized select switch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [5:0] MAX_COUNT = 6'd59;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-FF synchronizer, optional debounce, rising-edge pulse.
// Build option: STOPWATCH_DEBOUNCE_EN enables the debounce counter; without it
// the debounced level is the synchronizer output (raw-to-pulse = 2 cycles).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button, active-high
//   pulse      : one-cycle pulse on the rising edge of the conditioned level
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic meta, sync, level, level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle that sync
    // disagrees with it; any cycle of agreement reloads the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign level = sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_d <= 1'b0;
        else        level_d <= level;
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch timekeeping and control core: conditions the pause/clear buttons,
// runs the RUN/PAUSED/ADJUST machine and maintains the MM:SS count.
// Build option: STOPWATCH_DEBOUNCE_EN (see btn_conditioner).
// Ports:
//   masterClk, resetN  : clock, asynchronous active-low reset
//   oneHzEn / twoHzEn  : rate strobes (count advance / adjust advance)
//   pauseBtn, clearBtn : raw buttons, active-high
//   adjust, select     : raw switches (adjust mode; 0=minutes 1=seconds)
//   minutes, seconds   : current count, 0..59
//   paused             : high only in PAUSED
import stopwatch_pkg::*;

module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       masterClk,
    input  logic       resetN,
    input  logic       oneHzEn,
    input  logic       twoHzEn,
    input  logic       pauseBtn,
    input  logic       clearBtn,
    input  logic       adjust,
    input  logic       select,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       paused
);

    logic   pause_pulse, clear_pulse;
    logic   adj_meta, adj_sync, sel_meta, sel_sync;
    state_t state, state_nxt;
    logic [5:0] min_q, sec_q, min_nxt, sec_nxt;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(masterClk), .rst_n(resetN), .btn(pauseBtn), .pulse(pause_pulse)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(masterClk), .rst_n(resetN), .btn(clearBtn), .pulse(clear_pulse)
    );

    // Switches are only synchronized; they are levels, not events.
    always_ff @(posedge masterClk or negedge resetN) begin
        if (!resetN) begin
            adj_meta <= 1'b0;
            adj_sync <= 1'b0;
            sel_meta <= 1'b0;
            sel_sync <= 1'b0;
        end else begin
            adj_meta <= adjust;
            adj_sync <= adj_meta;
            sel_meta <= select;
            sel_sync <= sel_meta;
        end
    end

    always_ff @(posedge masterClk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_RUN;
            min_q <= '0;
            sec_q <= '0;
        end else begin
            state <= state_nxt;
            min_q <= min_nxt;
            sec_q <= sec_nxt;
        end
    end

    // Adjust switch outranks the pause pulse; leaving ADJUST lands in PAUSED
    // so the user restarts the count deliberately.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (adj_sync)         state_nxt = ST_ADJUST;
                       else if (pause_pulse) state_nxt = ST_PAUSED;
            ST_PAUSED: if (adj_sync)         state_nxt = ST_ADJUST;
                       else if (pause_pulse) state_nxt = ST_RUN;
            ST_ADJUST: if (!adj_sync)        state_nxt = ST_PAUSED;
            default:                         state_nxt = ST_RUN;
        endcase
    end

    // Strobes are qualified by the current state, not state_nxt. Clear wins.
    always_comb begin
        min_nxt = min_q;
        sec_nxt = sec_q;
        if (clear_pulse) begin
            min_nxt = '0;
            sec_nxt = '0;
        end else if (state == ST_RUN && oneHzEn) begin
            if (sec_q == MAX_COUNT) begin
                sec_nxt = '0;
                min_nxt = (min_q == MAX_COUNT) ? 6'd0 : min_q + 6'd1;
            end else begin
                sec_nxt = sec_q + 6'd1;
            end
        end else if (state == ST_ADJUST && twoHzEn) begin
            if (sel_sync == SEL_SEC)
                sec_nxt = (sec_q == MAX_COUNT) ? 6'd0 : sec_q + 6'd1;
            else
                min_nxt = (min_q == MAX_COUNT) ? 6'd0 : min_q + 6'd1;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign paused  = (state == ST_PAUSED);

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed self-checking bench for stopwatch_control (DEBOUNCE_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stopwatch_control;

    localparam int DB = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DB_LAT = 2 + DB;   // raw press to pulse
`else
    localparam int DB_LAT = 2;
`endif
    localparam int PRESS_LAT = DB_LAT + 1;  // raw press to state change

    logic       masterClk = 1'b0;
    logic       resetN = 1'b0;
    logic       oneHzEn = 1'b0, twoHzEn = 1'b0;
    logic       pauseBtn = 1'b0, clearBtn = 1'b0;
    logic       adjust = 1'b0, select = 1'b0;
    logic [5:0] minutes, seconds;
    logic       paused;

    int checks = 0;
    int failures = 0;

    stopwatch_control #(.DEBOUNCE_CYCLES(DB)) dut (
        .masterClk(masterClk), .resetN(resetN),
        .oneHzEn(oneHzEn), .twoHzEn(twoHzEn),
        .pauseBtn(pauseBtn), .clearBtn(clearBtn),
        .adjust(adjust), .select(select),
        .minutes(minutes), .seconds(seconds), .paused(paused)
    );

    always #5 masterClk = ~masterClk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge masterClk);
    endtask

    task automatic tick1(input int n);
        oneHzEn = 1'b1;
        cyc(n);
        oneHzEn = 1'b0;
    endtask

    task automatic tick2(input int n);
        twoHzEn = 1'b1;
        cyc(n);
        twoHzEn = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        chk({tag, ".min"}, int'(minutes), m);
        chk({tag, ".sec"}, int'(seconds), s);
    endtask

    // Hold pause 10 cycles, release and let the conditioner settle.
    task automatic press_pause();
        pauseBtn = 1'b1;
        cyc(10);
        pauseBtn = 1'b0;
        cyc(DB + 6);
    endtask

    initial begin
        cyc(2);
        chk_time("reset", 0, 0);
        chk("reset.paused", int'(paused), 0);
        resetN = 1'b1;
        cyc(2);

        // 61 seconds -> 01:01
        tick1(61);
        chk_time("count61", 1, 1);
        chk("count61.paused", int'(paused), 0);

        // asynchronous reset mid-run
        tick1(5);
        resetN = 1'b0;
        #1;
        chk_time("async_reset", 0, 0);
        cyc(2);
        resetN = 1'b1;
        cyc(1);

        // 59:58 -> 59:59 -> 00:00
        tick1(3598);
        chk_time("pre_wrap", 59, 58);
        tick1(1);
        chk_time("wrap_a", 59, 59);
        tick1(1);
        chk_time("wrap_b", 0, 0);

        tick1(3);
`ifdef STOPWATCH_DEBOUNCE_EN
        // press shorter than the debounce window is rejected
        pauseBtn = 1'b1;
        cyc(3);
        pauseBtn = 1'b0;
        cyc(12);
        chk("short_press.paused", int'(paused), 0);
`endif
        // press latency: 7 cycles with debounce, 3 without (1-cycle glitch)
        pauseBtn = 1'b1;
        for (int i = 1; i <= PRESS_LAT; i++) begin
            cyc(1);
`ifndef STOPWATCH_DEBOUNCE_EN
            if (i == 1) pauseBtn = 1'b0;
`endif
            if (i == PRESS_LAT - 1) chk("press_lat.before", int'(paused), 0);
        end
        chk("press_lat.after", int'(paused), 1);
        cyc(10 - PRESS_LAT);
        pauseBtn = 1'b0;
        cyc(DB + 6);

        tick1(5);
        chk_time("frozen", 0, 3);
        press_pause();
        chk("resume.paused", int'(paused), 0);
        tick1(1);
        chk_time("resume_count", 0, 4);

        // reach 12:58 in RUN, then adjust seconds
        resetN = 1'b0;
        cyc(1);
        resetN = 1'b1;
        cyc(1);
        tick1(778);
        chk_time("pre_adj", 12, 58);
        adjust = 1'b1;
        select = 1'b1;
        cyc(4);
        tick2(1);
        chk_time("adj1", 12, 59);
        tick2(1);
        chk_time("adj2", 12, 0);
        tick2(1);
        chk_time("adj3", 12, 1);
        tick1(3);
        chk_time("adj_ignore_1hz", 12, 1);
        chk("adj.paused", int'(paused), 0);
        tick2(33);
        chk_time("adj34", 12, 34);
        adjust = 1'b0;
        cyc(4);
        chk("adj_exit.paused", int'(paused), 1);
        tick2(2);
        chk_time("paused_ignore_2hz", 12, 34);

        // clear in PAUSED keeps the state
        clearBtn = 1'b1;
        cyc(10);
        clearBtn = 1'b0;
        cyc(DB + 6);
        chk_time("clear_paused", 0, 0);
        chk("clear_paused.paused", int'(paused), 1);

        // back to RUN, clear coincident with a tick
        press_pause();
        chk("run_again.paused", int'(paused), 0);
        tick1(2);
        chk_time("pre_clear", 0, 2);
        clearBtn = 1'b1;
        cyc(DB_LAT);
        tick1(1);
        chk_time("clear_vs_tick", 0, 0);
        cyc(10 - DB_LAT - 1);
        clearBtn = 1'b0;
        cyc(DB + 6);
        tick1(2);
        chk_time("post_clear", 0, 2);

        // pause pulse with a tick in RUN: count advances, then paused
        pauseBtn = 1'b1;
        cyc(DB_LAT);
        tick1(1);
        chk_time("pause_vs_tick", 0, 3);
        chk("pause_vs_tick.paused", int'(paused), 1);
        cyc(10 - DB_LAT - 1);
        pauseBtn = 1'b0;
        cyc(DB + 6);

        // adjust minutes from PAUSED: 59 increments wrap 0 -> 59
        select = 1'b0;
        adjust = 1'b1;
        cyc(4);
        tick2(59);
        chk_time("adj_min59", 59, 3);
        tick2(1);
        chk_time("adj_min_wrap", 0, 3);
        adjust = 1'b0;
        cyc(4);
        chk("final.paused", int'(paused), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
